eth_tx_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares the Ethernet MAC TX FIFO write port (AXI-Stream byte interface plus the UDP/IP header sideband) between NUM_PORTS requesters, e.g. the UDP TX path and the ARP responder.
- Sits in the i_clk (100 MHz) domain, directly upstream of the TX FIFO slave interface.
- A grant holds from the first beat to the tlast beat, so frames are never interleaved.

---
 rtl/eth_tx_arb_pkg.sv | 32 +++
 rtl/eth_tx_arbiter_rr_select.sv | 18 +
 rtl/eth_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_eth_tx_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arb_pkg.sv
// Shared types and helpers for the Ethernet TX arbiter.
package eth_tx_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    localparam int unsigned HDR_FIELD_W = 16;
    localparam int unsigned MAX_PORTS   = 8;

    // Round-robin pick: first set request at or after ptr, wrapping over n ports.
    // Returns ptr unchanged when no request is set.
    function automatic int unsigned rr_select(
        input logic [MAX_PORTS-1:0] req,
        input int unsigned          ptr,
        input int unsigned          n
    );
        logic [2:0] idx;
        logic       found;
        rr_select = ptr;
        found     = 1'b0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            idx = 3'((ptr + i) % n);
            if (!found && (i < n) && req[idx]) begin
                rr_select = 32'(idx);
                found     = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_select.sv
// Combinational round-robin priority selector (rotate / find-first-set / un-rotate).
module rr_priority_select
    import eth_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned PORT_W    = 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    ptr_i,
    output logic [PORT_W-1:0]    sel_o
);

    // Search order starts at ptr_i and wraps modulo NUM_PORTS.
    always_comb begin
        sel_o = PORT_W'(rr_select(MAX_PORTS'(req_i), 32'(ptr_i), NUM_PORTS));
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the MAC TX FIFO write port.
module eth_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 8,
    // Derived grant index width; leave at its default.
    parameter int unsigned PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]              s_axis_tlast,
    output logic [NUM_PORTS-1:0]              s_axis_trdy,
    input  logic [NUM_PORTS-1:0]              s_hdr_tvalid,
    input  logic [NUM_PORTS*HDR_FIELD_W-1:0]  s_udp_hdr_length,
    input  logic [NUM_PORTS*HDR_FIELD_W-1:0]  s_udp_hdr_checksum,
    input  logic [NUM_PORTS*HDR_FIELD_W-1:0]  s_ip_hdr_length,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_trdy,
    output logic                              m_hdr_tvalid,
    output logic [HDR_FIELD_W-1:0]            m_udp_hdr_length,
    output logic [HDR_FIELD_W-1:0]            m_udp_hdr_checksum,
    output logic [HDR_FIELD_W-1:0]            m_ip_hdr_length,
    output logic [PORT_W-1:0]                 o_grant,
    output logic                              o_busy
);

    arb_state_t             state_q, state_d;
    logic [PORT_W-1:0]      grant_q, grant_d;
    logic [PORT_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                   busy_q, busy_d;
    logic [PORT_W-1:0]      rr_sel;
    logic                   active;
    logic                   pkt_done;
    logic                   hdr_load;
    logic                   hdr_vld_q;
    logic [HDR_FIELD_W-1:0] udp_len_q, udp_csum_q, ip_len_q;

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_rr_select (
        .req_i (s_axis_tvalid),
        .ptr_i (rr_ptr_q),
        .sel_o (rr_sel)
    );

    // Zero-latency datapath mux from the granted port; nothing passes while idle.
    always_comb begin
        active        = (state_q == ACTIVE);
        m_axis_tdata  = s_axis_tdata[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tvalid = active & s_axis_tvalid[grant_q];
        m_axis_tlast  = active & s_axis_tlast[grant_q];
        s_axis_trdy   = '0;
        if (active) begin
            s_axis_trdy[grant_q] = m_axis_trdy;
        end
        pkt_done = m_axis_tvalid & m_axis_trdy & m_axis_tlast;
        hdr_load = active & s_hdr_tvalid[grant_q];
    end

    // Next-state: grant on any request in IDLE, release after the tlast handshake.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        busy_d   = busy_q;
        unique case (state_q)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_d = rr_sel;
                    state_d = ACTIVE;
                    busy_d  = 1'b1;
                end
            end
            ACTIVE: begin
                if (pkt_done) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    rr_ptr_d = (grant_q == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
        end
    end

    // Header sideband: capture the granted port's fields and strobe for one cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hdr_vld_q  <= 1'b0;
            udp_len_q  <= '0;
            udp_csum_q <= '0;
            ip_len_q   <= '0;
        end else begin
            hdr_vld_q <= hdr_load;
            if (hdr_load) begin
                udp_len_q  <= s_udp_hdr_length[32'(grant_q)*HDR_FIELD_W +: HDR_FIELD_W];
                udp_csum_q <= s_udp_hdr_checksum[32'(grant_q)*HDR_FIELD_W +: HDR_FIELD_W];
                ip_len_q   <= s_ip_hdr_length[32'(grant_q)*HDR_FIELD_W +: HDR_FIELD_W];
            end
        end
    end

    assign m_hdr_tvalid       = hdr_vld_q;
    assign m_udp_hdr_length   = udp_len_q;
    assign m_udp_hdr_checksum = udp_csum_q;
    assign m_ip_hdr_length    = ip_len_q;
    assign o_grant            = grant_q;
    assign o_busy             = busy_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter with a packet-level reference model.
module tb_eth_tx_arbiter;

    localparam int NP = 3;
    localparam int DW = 8;
    localparam int PW = 2;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b0;
    logic [NP*DW-1:0]   s_axis_tdata = '0;
    logic [NP-1:0]      s_axis_tvalid = '0;
    logic [NP-1:0]      s_axis_tlast = '0;
    logic [NP-1:0]      s_axis_trdy;
    logic [NP-1:0]      s_hdr_tvalid = '0;
    logic [NP*16-1:0]   s_udp_hdr_length = '0;
    logic [NP*16-1:0]   s_udp_hdr_checksum = '0;
    logic [NP*16-1:0]   s_ip_hdr_length = '0;
    logic [DW-1:0]      m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tlast;
    logic               m_axis_trdy = 1'b0;
    logic               m_hdr_tvalid;
    logic [15:0]        m_udp_hdr_length;
    logic [15:0]        m_udp_hdr_checksum;
    logic [15:0]        m_ip_hdr_length;
    logic [PW-1:0]      o_grant;
    logic               o_busy;

    eth_tx_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_trdy        (s_axis_trdy),
        .s_hdr_tvalid       (s_hdr_tvalid),
        .s_udp_hdr_length   (s_udp_hdr_length),
        .s_udp_hdr_checksum (s_udp_hdr_checksum),
        .s_ip_hdr_length    (s_ip_hdr_length),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_trdy        (m_axis_trdy),
        .m_hdr_tvalid       (m_hdr_tvalid),
        .m_udp_hdr_length   (m_udp_hdr_length),
        .m_udp_hdr_checksum (m_udp_hdr_checksum),
        .m_ip_hdr_length    (m_ip_hdr_length),
        .o_grant            (o_grant),
        .o_busy             (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Source beats awaiting acceptance and expected output beats, per port: {last, data}.
    logic [8:0]  src_q [NP][$];
    logic [8:0]  exp_q [NP][$];

    // Stimulus knobs (percent probabilities) and one-shot requests to the driver.
    int unsigned vprob = 100;
    int unsigned rprob = 100;
    int unsigned hprob = 0;
    int unsigned stall_left = 0;
    logic        hdr_req = 1'b0;
    logic [NP-1:0] hdr_req_vec = '0;
    logic [15:0] hdr_req_u [NP];
    logic [15:0] hdr_req_c [NP];
    logic [15:0] hdr_req_i [NP];

    int          n_in = 0;
    int          n_out = 0;
    int unsigned beats_out [NP];
    int unsigned grant_log [$];

    // Reference model state.
    logic        mb = 1'b0;
    int unsigned own = 0;
    int unsigned ptr = 0;
    logic        exp_hv = 1'b0;
    logic [15:0] eu = '0, ec = '0, ei = '0;
    logic        stall_p = 1'b0;
    logic [7:0]  stall_d = '0;

    initial begin
        for (int k = 0; k < NP; k++) begin
            beats_out[k] = 0;
            hdr_req_u[k] = '0;
            hdr_req_c[k] = '0;
            hdr_req_i[k] = '0;
        end
    end

    // Driver: holds each beat until accepted, random gaps, random FIFO-full, header strobes.
    initial begin : driver
        logic [NP-1:0] hs;
        forever begin
            @(negedge i_clk);
            hs = s_axis_tvalid & s_axis_trdy;
            @(posedge i_clk);
            #1;
            if (i_reset) begin
                s_axis_tvalid = '0;
                s_hdr_tvalid  = '0;
                m_axis_trdy   = 1'b0;
            end else begin
                for (int k = 0; k < NP; k++) begin
                    if (hs[k]) begin
                        if (src_q[k].size() > 0) void'(src_q[k].pop_front());
                        s_axis_tvalid[k] = 1'b0;
                    end
                    if (!s_axis_tvalid[k] && src_q[k].size() > 0 && $urandom_range(99) < vprob) begin
                        s_axis_tdata[k*DW +: DW] = src_q[k][0][7:0];
                        s_axis_tlast[k]          = src_q[k][0][8];
                        s_axis_tvalid[k]         = 1'b1;
                    end
                end
                if (stall_left > 0) begin
                    m_axis_trdy = 1'b0;
                    stall_left  = stall_left - 1;
                end else begin
                    m_axis_trdy = ($urandom_range(99) < rprob);
                end
                if (hdr_req) begin
                    s_hdr_tvalid = hdr_req_vec;
                    for (int k = 0; k < NP; k++) begin
                        s_udp_hdr_length[k*16 +: 16]   = hdr_req_u[k];
                        s_udp_hdr_checksum[k*16 +: 16] = hdr_req_c[k];
                        s_ip_hdr_length[k*16 +: 16]    = hdr_req_i[k];
                    end
                    hdr_req = 1'b0;
                end else begin
                    for (int k = 0; k < NP; k++) begin
                        s_hdr_tvalid[k] = ($urandom_range(99) < hprob);
                        s_udp_hdr_length[k*16 +: 16]   = 16'($urandom);
                        s_udp_hdr_checksum[k*16 +: 16] = 16'($urandom);
                        s_ip_hdr_length[k*16 +: 16]    = 16'($urandom);
                    end
                end
            end
        end
    end

    // Monitor: applies the arbitration rules per cycle and pops the scoreboard on each output beat.
    always @(negedge i_clk) begin : monitor
        logic [NP-1:0] etr;
        logic [8:0]    b;
        logic          nhv;
        logic          found;
        int unsigned   idx;
        if (i_reset) begin
            chk("rst_s_trdy", 32'(s_axis_trdy), 0);
            chk("rst_m_tvalid", 32'(m_axis_tvalid), 0);
            chk("rst_busy", 32'(o_busy), 0);
            chk("rst_grant", 32'(o_grant), 0);
            chk("rst_hdr_tvalid", 32'(m_hdr_tvalid), 0);
            chk("rst_hdr_udp_len", 32'(m_udp_hdr_length), 0);
            chk("rst_hdr_csum", 32'(m_udp_hdr_checksum), 0);
            chk("rst_hdr_ip_len", 32'(m_ip_hdr_length), 0);
            mb = 1'b0; own = 0; ptr = 0; exp_hv = 1'b0;
            eu = '0; ec = '0; ei = '0; stall_p = 1'b0;
        end else begin
            chk("hdr_tvalid", 32'(m_hdr_tvalid), 32'(exp_hv));
            chk("hdr_udp_len", 32'(m_udp_hdr_length), 32'(eu));
            chk("hdr_csum", 32'(m_udp_hdr_checksum), 32'(ec));
            chk("hdr_ip_len", 32'(m_ip_hdr_length), 32'(ei));
            nhv = 1'b0;
            if (!mb) begin
                chk("idle_s_trdy", 32'(s_axis_trdy), 0);
                chk("idle_m_tvalid", 32'(m_axis_tvalid), 0);
                chk("idle_busy", 32'(o_busy), 0);
                found = 1'b0;
                for (int i = 0; i < NP; i++) begin
                    idx = (ptr + 32'(i)) % NP;
                    if (!found && s_axis_tvalid[idx]) begin
                        found = 1'b1;
                        own   = idx;
                    end
                end
                if (found) begin
                    mb = 1'b1;
                    grant_log.push_back(own);
                end
            end else begin
                etr = '0;
                if (m_axis_trdy) etr[own] = 1'b1;
                chk("act_grant", 32'(o_grant), own);
                chk("act_busy", 32'(o_busy), 1);
                chk("act_s_trdy", 32'(s_axis_trdy), 32'(etr));
                chk("act_m_tvalid", 32'(m_axis_tvalid), 32'(s_axis_tvalid[own]));
                if (s_hdr_tvalid[own]) begin
                    nhv = 1'b1;
                    eu  = s_udp_hdr_length[own*16 +: 16];
                    ec  = s_udp_hdr_checksum[own*16 +: 16];
                    ei  = s_ip_hdr_length[own*16 +: 16];
                end
                if (stall_p && m_axis_tvalid) chk("stall_data_hold", 32'(m_axis_tdata), 32'(stall_d));
                stall_p = 1'b0;
                if (m_axis_tvalid && m_axis_trdy) begin
                    chk("beat_expected", 32'(exp_q[own].size() != 0), 1);
                    if (exp_q[own].size() != 0) begin
                        b = exp_q[own].pop_front();
                        chk("out_data", 32'(m_axis_tdata), 32'(b[7:0]));
                        chk("out_last", 32'(m_axis_tlast), 32'(b[8]));
                        n_out++;
                        beats_out[own]++;
                        if (b[8]) begin
                            mb  = 1'b0;
                            ptr = (own + 1) % NP;
                        end
                    end
                end else if (m_axis_tvalid) begin
                    stall_p = 1'b1;
                    stall_d = m_axis_tdata;
                end
            end
            exp_hv = nhv;
        end
    end

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic pkt(input int k, input int len, input bit rnd, input logic [7:0] base);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = rnd ? 8'($urandom) : base + 8'(i);
            src_q[k].push_back({(i == len - 1), d});
            exp_q[k].push_back({(i == len - 1), d});
            n_in++;
        end
    endtask

    function automatic int pending();
        int p;
        p = mb ? 1 : 0;
        for (int k = 0; k < NP; k++) p += src_q[k].size() + exp_q[k].size();
        return p;
    endfunction

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (c < budget && pending() != 0) begin
            tick();
            c++;
        end
        chk("drain_pending", 32'(pending()), 0);
    endtask

    function automatic logic [31:0] glog(input int i);
        if (i < grant_log.size()) return 32'(grant_log[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic flush_queues();
        for (int k = 0; k < NP; k++) begin
            n_in -= exp_q[k].size();
            exp_q[k].delete();
            src_q[k].delete();
        end
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        flush_queues();
        tick();
        @(posedge i_clk);
        #2;
        i_reset = 1'b0;
    endtask

    initial begin : main
        int gl;
        int c;
        int unsigned base;

        #1 i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        #2 i_reset = 1'b0;

        // Single port, 4 beats 0x11..0x14.
        pkt(0, 4, 1'b0, 8'h11);
        drain(100);

        // Simultaneous requests from reset: port 0 then port 1.
        do_reset();
        gl = grant_log.size();
        pkt(0, 3, 1'b0, 8'h21);
        pkt(1, 3, 1'b0, 8'h31);
        drain(100);
        chk("simul_grant_first", glog(gl), 0);
        chk("simul_grant_second", glog(gl + 1), 1);

        // Fairness: both ports request continuously.
        gl = grant_log.size();
        pkt(0, 2, 1'b1, 8'h00);
        pkt(1, 3, 1'b1, 8'h00);
        pkt(0, 1, 1'b1, 8'h00);
        pkt(1, 2, 1'b1, 8'h00);
        drain(100);
        for (int i = 0; i < 4; i++) chk("fair_grant_order", glog(gl + i), 32'(i % 2));

        // Backpressure: FIFO full for 5 cycles mid-packet.
        base = beats_out[1];
        pkt(1, 8, 1'b1, 8'h00);
        c = 0;
        do begin tick(); c++; end while (beats_out[1] < base + 3 && c < 50);
        chk("bp_reached_beat3", 32'(beats_out[1] >= base + 3), 1);
        stall_left = 5;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_s_trdy_low", 32'(s_axis_trdy[1]), 0);
            chk("bp_m_tvalid_held", 32'(m_axis_tvalid), 1);
        end
        drain(100);

        // Header strobe on granted port 1 with a simultaneous port 0 strobe.
        pkt(1, 6, 1'b1, 8'h00);
        c = 0;
        do begin tick(); c++; end while (!(o_busy && o_grant == 2'd1) && c < 50);
        chk("hdr_port1_granted", 32'(o_busy && o_grant == 2'd1), 1);
        hdr_req_vec  = 3'b011;
        hdr_req_u[0] = 16'h1111; hdr_req_c[0] = 16'h2222; hdr_req_i[0] = 16'h3333;
        hdr_req_u[1] = 16'h001C; hdr_req_c[1] = 16'hBEEF; hdr_req_i[1] = 16'h0030;
        hdr_req = 1'b1;
        tick();
        tick();
        chk("hdr_dir_tvalid", 32'(m_hdr_tvalid), 1);
        chk("hdr_dir_udp_len", 32'(m_udp_hdr_length), 32'h001C);
        chk("hdr_dir_csum", 32'(m_udp_hdr_checksum), 32'hBEEF);
        chk("hdr_dir_ip_len", 32'(m_ip_hdr_length), 32'h0030);
        tick();
        chk("hdr_dir_pulse_end", 32'(m_hdr_tvalid), 0);
        chk("hdr_dir_hold", 32'(m_udp_hdr_length), 32'h001C);
        drain(100);

        // Reset after beat 2 of a 5-beat port 1 packet.
        pkt(0, 3, 1'b1, 8'h00);
        base = beats_out[1];
        pkt(1, 5, 1'b1, 8'h00);
        c = 0;
        do begin tick(); c++; end while (beats_out[1] < base + 2 && c < 50);
        chk("rst_reached_beat2", 32'(beats_out[1] >= base + 2), 1);
        @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        flush_queues();
        #1;
        chk("rst_imm_s_trdy", 32'(s_axis_trdy), 0);
        chk("rst_imm_m_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_imm_busy", 32'(o_busy), 0);
        tick();
        @(posedge i_clk);
        #2;
        i_reset = 1'b0;
        gl = grant_log.size();
        pkt(0, 2, 1'b1, 8'h00);
        pkt(1, 2, 1'b1, 8'h00);
        drain(100);
        chk("post_rst_grant", glog(gl), 0);

        // Random traffic over all ports.
        vprob = 60;
        rprob = 70;
        hprob = 10;
        for (int i = 0; i < 30; i++) pkt(int'($urandom_range(NP - 1)), int'($urandom_range(6, 1)), 1'b1, 8'h00);
        drain(6000);
        hprob = 0;

        chk("beats_in_eq_out", 32'(n_out), 32'(n_in));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
